// File: rtl/unit1to3.sv
`default_nettype none
// ============================================================================
//  Module   : unit1to3
//  Purpose  : Learnable one-input, three-output fan-out unit for the bitnet
//             datapath. The forward phase broadcasts one activation bit
//             through three binary weights. The backward phase reduces three
//             error bits to one by majority vote and trains the weights with
//             saturating signed vote counters.
//  Options  : UNIT1TO3_STOCHASTIC_EN -- when defined, weight and counter
//             updates are also gated by the oscillator input.
//  Revision : 1.0 - initial release
// ============================================================================
module unit1to3 #(
   parameter int CNT_W = 3
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       oscillator,
   input  logic       fd_prop,
   input  logic       bk_prop,
   input  logic       fin,
   input  logic [2:0] bin,
   output logic       control_out,
   output logic [2:0] fout,
   output logic       bout
);

   // Counter limits and unit step, all at the counter's own signed width
   localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic signed [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

   // Architectural state
   logic [2:0]              w_q, w_d;
   logic signed [CNT_W-1:0] cnt_q [3];
   logic signed [CNT_W-1:0] cnt_d [3];
   logic                    x_q, x_d;
   logic [2:0]              fout_q, fout_d;
   logic                    bout_q, bout_d;
   logic                    control_q, control_d;

   // Phase decode: a forward strobe always masks a concurrent backward strobe
   logic fwd_en;
   logic bwd_en;
   logic upd_en;
   logic [2:0] match;   // bin[i] XNOR w[i], the per-branch error after weighting
   logic [2:0] vote;    // 1 = increment counter i, 0 = decrement
   logic [2:0] flip;

   assign fwd_en = fd_prop;
   assign bwd_en = bk_prop & ~fd_prop;

`ifdef UNIT1TO3_STOCHASTIC_EN
   assign upd_en = bwd_en & oscillator;
`else
   // oscillator has no function in the deterministic build
   logic osc_unused;
   assign osc_unused = oscillator;
   assign upd_en     = bwd_en;
`endif

   assign match = ~(bin ^ w_q);
   assign vote  = ~(bin ^ {3{x_q}});

   // Next-state: forward latch, backward majority and per-branch vote counters
   always_comb begin
      w_d       = w_q;
      x_d       = x_q;
      fout_d    = fout_q;
      bout_d    = bout_q;
      flip      = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      if (fwd_en) begin
         x_d    = fin;
         fout_d = ~(w_q ^ {3{fin}});
      end

      if (bwd_en) begin
         // Majority uses the weights as they stand before this edge's update
         bout_d = (match[0] & match[1]) | (match[0] & match[2]) | (match[1] & match[2]);
      end

      if (upd_en) begin
         for (int i = 0; i < 3; i++) begin
            if (vote[i]) begin
               if (cnt_q[i] < CNT_MAX) begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end else if (!w_q[i]) begin
                  // Overflow on an inverting weight: flip it to pass
                  w_d[i]   = 1'b1;
                  cnt_d[i] = CNT_ZERO;
                  flip[i]  = 1'b1;
               end
            end else begin
               if (cnt_q[i] > CNT_MIN) begin
                  cnt_d[i] = cnt_q[i] - CNT_ONE;
               end else if (w_q[i]) begin
                  // Underflow on a passing weight: flip it to invert
                  w_d[i]   = 1'b0;
                  cnt_d[i] = CNT_ZERO;
                  flip[i]  = 1'b1;
               end
            end
         end
      end

      control_d = |flip;
   end

   // State register; reset dominates any strobe in the same cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         w_q       <= 3'b111;
         x_q       <= 1'b0;
         fout_q    <= 3'b000;
         bout_q    <= 1'b0;
         control_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         w_q       <= w_d;
         x_q       <= x_d;
         fout_q    <= fout_d;
         bout_q    <= bout_d;
         control_q <= control_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign fout        = fout_q;
   assign bout        = bout_q;
   assign control_out = control_q;

endmodule
`default_nettype wire

// File: tb/tb_unit1to3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unit1to3
//  Purpose  : Directed self-checking bench for unit1to3 (CNT_W = 3, counter
//             range -4..+3). Expected values are hand-derived per step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unit1to3;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       oscillator = 1'b0;
   logic       fd_prop = 1'b0;
   logic       bk_prop = 1'b0;
   logic       fin = 1'b0;
   logic [2:0] bin = 3'b000;
   logic       control_out;
   logic [2:0] fout;
   logic       bout;

   int n_checks = 0;
   int n_fail   = 0;

   unit1to3 #(.CNT_W(3)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .oscillator  (oscillator),
      .fd_prop     (fd_prop),
      .bk_prop     (bk_prop),
      .fin         (fin),
      .bin         (bin),
      .control_out (control_out),
      .fout        (fout),
      .bout        (bout)
   );

   always #5 clk_in = ~clk_in;

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_in  = 1'b1;
      fd_prop = 1'b0;
      bk_prop = 1'b0;
      step();
      step();
      rst_in  = 1'b0;
   endtask

   task automatic do_fd(input logic f);
      fd_prop = 1'b1;
      fin     = f;
      step();
      fd_prop = 1'b0;
   endtask

   task automatic do_bk(input logic [2:0] b, input logic osc);
      bk_prop    = 1'b1;
      bin        = b;
      oscillator = osc;
      step();
      bk_prop    = 1'b0;
   endtask

   initial begin
      // 1: reset and forward pass
      do_reset();
      chk("rst_fout", fout, 3'b000);
      chk("rst_bout", {2'b00, bout}, 3'b000);
      chk("rst_ctrl", {2'b00, control_out}, 3'b000);
      do_fd(1'b1);
      chk("fwd1_fout", fout, 3'b111);
      chk("fwd1_bout", {2'b00, bout}, 3'b000);
      chk("fwd1_ctrl", {2'b00, control_out}, 3'b000);
      do_fd(1'b0);
      chk("fwd0_fout", fout, 3'b000);
      step();
      chk("idle_fout_hold", fout, 3'b000);

      // 2: backward majority with w=111
      do_bk(3'b011, 1'b1);
      chk("maj011_bout", {2'b00, bout}, 3'b001);
      step();
      chk("idle_bout_hold", {2'b00, bout}, 3'b001);
      do_bk(3'b001, 1'b1);
      chk("maj001_bout", {2'b00, bout}, 3'b000);

      // 3: downward flip after five decrements from x=1
      do_reset();
      do_fd(1'b1);
      for (int k = 0; k < 4; k++) begin
         do_bk(3'b000, 1'b1);
         chk($sformatf("dn_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b000, 1'b1);
      chk("dn_flip_ctrl", {2'b00, control_out}, 3'b001);
      chk("dn_flip_bout", {2'b00, bout}, 3'b000);
      step();
      chk("dn_ctrl_oneshot", {2'b00, control_out}, 3'b000);
      do_fd(1'b1);
      chk("dn_fout_inv1", fout, 3'b000);
      do_fd(1'b0);
      chk("dn_fout_inv0", fout, 3'b111);

      // 4: saturation at +3 without flip, then seven steps down to -4
      do_reset();
      do_fd(1'b1);
      for (int k = 0; k < 10; k++) begin
         do_bk(3'b111, 1'b1);
         chk($sformatf("sat_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      chk("sat_bout", {2'b00, bout}, 3'b001);
      do_fd(1'b1);
      chk("sat_fout", fout, 3'b111);
      for (int k = 0; k < 7; k++) begin
         do_bk(3'b000, 1'b1);
         chk($sformatf("sat_dn_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b000, 1'b1);
      chk("sat_dn_flip", {2'b00, control_out}, 3'b001);

      // 5a: oscillator gating
      do_reset();
      do_fd(1'b1);
`ifdef UNIT1TO3_STOCHASTIC_EN
      for (int k = 0; k < 5; k++) begin
         do_bk(3'b000, 1'b0);
         chk($sformatf("gate_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_fd(1'b1);
      chk("gate_fout", fout, 3'b111);
      for (int k = 0; k < 4; k++) begin
         do_bk(3'b000, 1'b1);
         chk($sformatf("gate_run_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b000, 1'b1);
      chk("gate_run_flip", {2'b00, control_out}, 3'b001);
`else
      // oscillator is ignored: low oscillator still trains
      for (int k = 0; k < 4; k++) begin
         do_bk(3'b000, 1'b0);
         chk($sformatf("nogate_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b000, 1'b0);
      chk("nogate_flip", {2'b00, control_out}, 3'b001);
`endif

      // 5b: fd/bk collision -- forward wins, backward ignored
      do_reset();
      do_fd(1'b1);
      do_bk(3'b111, 1'b1);           // counters -> +1, bout -> 1
      chk("col_pre_bout", {2'b00, bout}, 3'b001);
      fd_prop = 1'b1;
      bk_prop = 1'b1;
      fin     = 1'b0;
      bin     = 3'b000;
      step();
      fd_prop = 1'b0;
      bk_prop = 1'b0;
      chk("col_fout", fout, 3'b000);
      chk("col_bout_hold", {2'b00, bout}, 3'b001);
      chk("col_ctrl", {2'b00, control_out}, 3'b000);
      // x is now 0, so bin=111 votes decrement: +1 -> -4 takes five steps
      for (int k = 0; k < 5; k++) begin
         do_bk(3'b111, 1'b1);
         chk($sformatf("col_dn_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b111, 1'b1);
      chk("col_dn_flip", {2'b00, control_out}, 3'b001);

      // 6: reset coincident with bk_prop mid-operation
      do_reset();
      do_fd(1'b1);
      for (int k = 0; k < 3; k++) begin
         do_bk(3'b000, 1'b1);
      end
      rst_in     = 1'b1;
      bk_prop    = 1'b1;
      bin        = 3'b000;
      step();
      rst_in     = 1'b0;
      bk_prop    = 1'b0;
      chk("mid_rst_fout", fout, 3'b000);
      chk("mid_rst_ctrl", {2'b00, control_out}, 3'b000);
      do_fd(1'b1);
      chk("mid_rst_w", fout, 3'b111);
      for (int k = 0; k < 4; k++) begin
         do_bk(3'b000, 1'b1);
         chk($sformatf("mid_rst_ctrl_%0d", k), {2'b00, control_out}, 3'b000);
      end
      do_bk(3'b000, 1'b1);
      chk("mid_rst_flip", {2'b00, control_out}, 3'b001);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unit1to3.md
# unit1to3

Learnable one-input, three-output fan-out unit for the bitnet datapath. It is the mirror of the three-to-one reduction unit: the forward phase broadcasts one activation bit through three stored binary weights, and the backward phase collapses three error bits into one. Each weight carries a saturating vote counter and flips when that counter overflows. It sits between a single-output neuron and three downstream units, sharing the same `fd_prop`/`bk_prop`/`oscillator` phase control as the rest of the network.

## Interface
- `CNT_W`, default 3: width of each signed vote counter; range −2^(CNT_W−1) .. 2^(CNT_W−1)−1.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `oscillator`  in  1  stochastic update enable, sampled on `bk_prop` cycles.
- `fd_prop`  in  1  forward-phase strobe, one cycle wide.
- `bk_prop`  in  1  backward-phase strobe, one cycle wide.
- `fin`  in  1  forward activation bit.
- `bin`  in  3  backward error bits, one per output branch.
- `control_out`  out  1  one-cycle pulse: at least one weight flipped.
- `fout`  out  3  forward outputs, registered.
- `bout`  out  1  backward output, registered.

## Operation
- **State:**
  - `w[2:0]`: weights; 1 = pass, 0 = invert.
  - `cnt[i]`: three signed `CNT_W`-bit counters.
  - `x`: latched forward input.
- **Forward, `fd_prop`=1:**
  - `x` ← `fin`.
  - `fout[i]` ← `fin` XNOR `w[i]`.
- **Backward, `bk_prop`=1 and `fd_prop`=0:**
  - `bout` ← majority over i of (`bin[i]` XNOR `w[i]`), using pre-update weights.
  - Vote `v[i]` = `bin[i]` XNOR `x`; 1 means increment, 0 means decrement.
  - Update is enabled when the update-enable condition holds (see Configuration).
- **Counter update, per i, when enabled:**
  - Increment while `cnt[i]` < max. At max: if `w[i]`=0, set `w[i]`←1 and `cnt[i]`←0 (flip); otherwise hold at max.
  - Decrement while `cnt[i]` > min. At min: if `w[i]`=1, set `w[i]`←0 and `cnt[i]`←0 (flip); otherwise hold at min.
- `control_out` ← 1 for exactly the cycle after any flip; otherwise 0.
- **Simultaneous `fd_prop` and `bk_prop`:** the forward phase executes and the backward phase is ignored entirely (no `bout` update, no counter change).
- **Idle** (neither strobe): `fout`, `bout`, `w`, `cnt`, and `x` hold; `control_out`=0.
- **Reset:**
  - Outputs: `fout`=3'b000, `bout`=0, `control_out`=0.
  - State: `w`=3'b111, all `cnt`=0, `x`=0.
  - Reset wins over any concurrent strobe, including mid-phase.

## Timing
- `fout`: valid the cycle after `fd_prop`; held until the next `fd_prop` or reset.
- `bout` and `control_out`: valid the cycle after `bk_prop`.
- Weight flips take effect on the same edge that registers `bout`, so the next `fd_prop` uses the new weights.
- Back-to-back strobes, one per cycle, are supported with no bubbles.
- All three counters update in parallel; multiple flips in one cycle produce a single `control_out` pulse.

## Configuration
- Macro: `UNIT1TO3_STOCHASTIC_EN`.
- **Defined:** update-enable = `bk_prop` AND NOT `fd_prop` AND `oscillator`. With `oscillator`=0, `bout` still updates but counters and weights hold.
- **Undefined:** `oscillator` is ignored and update-enable = `bk_prop` AND NOT `fd_prop`.

## Test plan
Scenarios 3–5 use `CNT_W`=3 (counter range −4..+3).
1. **Reset and forward pass:** reset, then `fd_prop` with `fin`=1 → next cycle `fout`=3'b111. Then `fd_prop` with `fin`=0 → `fout`=3'b000. `bout`=0 and `control_out`=0 throughout.
2. **Backward majority:** with `w`=111, `bk_prop` with `bin`=3'b011 → `bout`=1; with `bin`=3'b001 → `bout`=0.
3. **Downward flip:** `fd_prop` with `fin`=1, then five `bk_prop` with `bin`=000 and `oscillator`=1.
   - `cnt` goes −1, −2, −3, −4.
   - The 5th `bk_prop` flips `w` to 000 and `control_out` pulses once.
   - A following `fd_prop` with `fin`=1 → `fout`=000.
4. **Saturation without flip:** from reset with `x`=1, ten `bk_prop` with `bin`=111.
   - Counters saturate at +3.
   - `w` stays 111 and `control_out` never pulses.
5. **Gating and collision:**
   - With the macro defined and `oscillator`=0, five decrement `bk_prop`s → no counter change and `w`=111.
   - Assert `fd_prop` and `bk_prop` together with `fin`=0 → `fout`=000 and counters unchanged.
6. **Reset mid-operation:** reach `cnt`=−3, then assert `rst_in` coincident with `bk_prop` → `w`=111, `cnt`=0. The next four decrement `bk_prop`s produce no flip.
